// File: rtl/fight_pkg.sv
// Shared fight constants, match state and winner codes.
// Also used by the colour mapper and the projectile launcher.
package fight_pkg;

    typedef enum logic {FIGHT, KO} match_state_t;

    typedef logic [1:0] winner_t;
    localparam winner_t WIN_NONE = 2'b00;
    localparam winner_t WIN_HP   = 2'b01;
    localparam winner_t WIN_NPC  = 2'b10;
    localparam winner_t WIN_DRAW = 2'b11;

    localparam logic [9:0] HIT_RADIUS    = 10'd40;
    localparam logic [6:0] DAMAGE        = 7'd10;
    localparam logic [6:0] MAX_HEALTH    = 7'd100;
    localparam logic [5:0] INVULN_FRAMES = 6'd30;
    localparam logic [6:0] KO_HOLD       = 7'd120;
    localparam logic [9:0] BAR_Y         = 10'd50;
    localparam logic [9:0] BAR_H         = 10'd15;
    localparam logic [9:0] HP_BAR_END    = 10'd600;
    localparam logic [9:0] NPC_BAR_START = 10'd40;

    // Operands are zero-extended so the difference never wraps.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] ea;
        logic [10:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

endpackage

// File: rtl/beat_hit_resolver_if.sv
// Projectile / fighter position inputs and health / match outputs of the hit resolver.
interface beat_hit_resolver_if;
    logic       is_HPBeat;
    logic       is_NPCBeat;
    logic [9:0] HP_X;
    logic [9:0] NPC_X;
    logic [9:0] HP_X_Pos;
    logic [9:0] NPC_X_Pos;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [6:0] hp_health;
    logic [6:0] npc_health;
    logic       hp_hurt;
    logic       npc_hurt;
    logic       hit_hp;
    logic       hit_npc;
    logic       game_over;
    logic [1:0] winner;
    logic       is_blood;
    logic       blood_color;

    modport master (
        output is_HPBeat, is_NPCBeat, HP_X, NPC_X, HP_X_Pos, NPC_X_Pos, DrawX, DrawY,
        input  hp_health, npc_health, hp_hurt, npc_hurt, hit_hp, hit_npc,
               game_over, winner, is_blood, blood_color
    );

    modport slave (
        input  is_HPBeat, is_NPCBeat, HP_X, NPC_X, HP_X_Pos, NPC_X_Pos, DrawX, DrawY,
        output hp_health, npc_health, hp_hurt, npc_hurt, hit_hp, hit_npc,
               game_over, winner, is_blood, blood_color
    );
endinterface

// File: rtl/beat_hit_channel.sv
// One projectile -> target direction: range check, one-hit-per-projectile latch,
// invulnerability window and saturating health of the target fighter.
module beat_hit_channel
    import fight_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       en,
    input  logic       beat,
    input  logic [9:0] proj_x,
    input  logic [9:0] tgt_x,
    output logic [6:0] health,
    output logic [6:0] health_nxt,
    output logic       hurt,
    output logic       hit
);
    logic       used_q, used_d;
    logic [5:0] inv_q, inv_d;
    logic [6:0] health_q, health_d;
    logic       hit_q, hit_d;

    always_comb begin
        hit_d = en && beat && !used_q && (inv_q == 6'd0) &&
                (abs_diff(proj_x, tgt_x) < {1'b0, HIT_RADIUS});
        used_d   = used_q;
        inv_d    = (inv_q != 6'd0) ? inv_q - 6'd1 : 6'd0;
        health_d = health_q;
        // A miss inside the window leaves the latch clear so the projectile can still land later.
        if (!beat)      used_d = 1'b0;
        else if (hit_d) used_d = 1'b1;
        if (hit_d) begin
            inv_d    = INVULN_FRAMES;
            health_d = (health_q <= DAMAGE) ? 7'd0 : health_q - DAMAGE;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            used_q   <= 1'b0;
            inv_q    <= 6'd0;
            health_q <= MAX_HEALTH;
            hit_q    <= 1'b0;
        end else begin
            used_q   <= used_d;
            inv_q    <= inv_d;
            health_q <= health_d;
            hit_q    <= hit_d;
        end
    end

    assign health     = health_q;
    assign health_nxt = health_d;
    assign hurt       = (inv_q != 6'd0);
    assign hit        = hit_q;
endmodule

// File: rtl/beat_hit_resolver.sv
// Collision/damage resolver: two hit channels, FIGHT/KO match FSM with winner latch,
// and combinational health-bar pixel flags.
module beat_hit_resolver
    import fight_pkg::*;
(
    input  logic                frame_clk,
    input  logic                Reset,
    beat_hit_resolver_if.slave  bus
);
    match_state_t state_q, state_d;
    winner_t      winner_q, winner_d;
    logic [6:0]   ko_cnt_q, ko_cnt_d;
    logic [6:0]   hp_nxt, npc_nxt;
    logic         fight;

    assign fight = (state_q == FIGHT);

    beat_hit_channel u_to_npc (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .en        (fight),
        .beat      (bus.is_HPBeat),
        .proj_x    (bus.HP_X),
        .tgt_x     (bus.NPC_X_Pos),
        .health    (bus.npc_health),
        .health_nxt(npc_nxt),
        .hurt      (bus.npc_hurt),
        .hit       (bus.hit_npc)
    );

    beat_hit_channel u_to_hp (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .en        (fight),
        .beat      (bus.is_NPCBeat),
        .proj_x    (bus.NPC_X),
        .tgt_x     (bus.HP_X_Pos),
        .health    (bus.hp_health),
        .health_nxt(hp_nxt),
        .hurt      (bus.hp_hurt),
        .hit       (bus.hit_hp)
    );

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        ko_cnt_d = ko_cnt_q;
        case (state_q)
            FIGHT: begin
                // KO lands on the same edge as the killing hit.
                if (hp_nxt == 7'd0 || npc_nxt == 7'd0) begin
                    state_d  = KO;
                    winner_d = (hp_nxt == 7'd0 && npc_nxt == 7'd0) ? WIN_DRAW :
                               (npc_nxt == 7'd0)                    ? WIN_HP   : WIN_NPC;
                end
            end
            KO: begin
                if (ko_cnt_q != KO_HOLD) ko_cnt_d = ko_cnt_q + 7'd1;
            end
            default: state_d = FIGHT;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q  <= FIGHT;
            winner_q <= WIN_NONE;
            ko_cnt_q <= 7'd0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            ko_cnt_q <= ko_cnt_d;
        end
    end

    assign bus.game_over = (state_q == KO);
    assign bus.winner    = winner_q;

    logic in_rows, in_hp_bar, in_npc_bar;
    always_comb begin
        in_rows    = (bus.DrawY >= BAR_Y) && (bus.DrawY <= BAR_Y + BAR_H);
        in_hp_bar  = in_rows && (bus.DrawX >= HP_BAR_END - {3'b0, MAX_HEALTH}) &&
                     (bus.DrawX <= HP_BAR_END);
        in_npc_bar = in_rows && (bus.DrawX >= NPC_BAR_START) &&
                     (bus.DrawX <= NPC_BAR_START + {3'b0, MAX_HEALTH});
        bus.is_blood    = in_hp_bar || in_npc_bar;
        bus.blood_color = 1'b0;
        // HP bar drains from its left end, NPC bar from its right end.
        if (in_hp_bar)
            bus.blood_color = (bus.DrawX >= HP_BAR_END - {3'b0, bus.hp_health});
        else if (in_npc_bar)
            bus.blood_color = (bus.DrawX <= NPC_BAR_START + {3'b0, bus.npc_health});
    end
endmodule

// File: tb/tb_beat_hit_resolver.sv
// Self-checking bench: per-frame reference model of the fight rules plus directed scenarios.
module tb_beat_hit_resolver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    beat_hit_resolver_if bus ();
    beat_hit_resolver dut (.frame_clk(clk), .Reset(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_hp, m_npc, m_hp_inv, m_npc_inv, m_win;
    bit m_hp_used, m_npc_used, m_ko, m_hit_hp, m_hit_npc;

    function automatic int absd(int a, int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic logic [20:0] exp_vec();
        return {7'(m_hp), 7'(m_npc), m_hp_inv != 0, m_npc_inv != 0,
                m_hit_hp, m_hit_npc, m_ko, 2'(m_win)};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {bus.hp_health, bus.npc_health, bus.hp_hurt, bus.npc_hurt,
                bus.hit_hp, bus.hit_npc, bus.game_over, bus.winner};
    endfunction

    // expected {is_blood, blood_color} from bar geometry
    function automatic logic [1:0] exp_bar(int x, int y, int hp, int npc);
        if (y < 50 || y > 65) return 2'b00;
        if (x >= 500 && x <= 600) return {1'b1, x >= 600 - hp};
        if (x >= 40 && x <= 140) return {1'b1, x <= 40 + npc};
        return 2'b00;
    endfunction

    task automatic tick();
        bit hn, hh;
        int nn, nh;
        if (rst) begin
            m_hp = 100; m_npc = 100; m_hp_inv = 0; m_npc_inv = 0; m_win = 0;
            m_hp_used = 0; m_npc_used = 0; m_ko = 0; m_hit_hp = 0; m_hit_npc = 0;
        end else begin
            hn = !m_ko && bus.is_HPBeat && !m_hp_used && m_npc_inv == 0 &&
                 absd(int'(bus.HP_X), int'(bus.NPC_X_Pos)) < 40;
            hh = !m_ko && bus.is_NPCBeat && !m_npc_used && m_hp_inv == 0 &&
                 absd(int'(bus.NPC_X), int'(bus.HP_X_Pos)) < 40;
            nn = hn ? ((m_npc > 10) ? m_npc - 10 : 0) : m_npc;
            nh = hh ? ((m_hp > 10) ? m_hp - 10 : 0) : m_hp;
            m_npc_inv = hn ? 30 : (m_npc_inv > 0 ? m_npc_inv - 1 : 0);
            m_hp_inv  = hh ? 30 : (m_hp_inv > 0 ? m_hp_inv - 1 : 0);
            m_hp_used  = !bus.is_HPBeat  ? 1'b0 : (hn ? 1'b1 : m_hp_used);
            m_npc_used = !bus.is_NPCBeat ? 1'b0 : (hh ? 1'b1 : m_npc_used);
            if (!m_ko && (nn == 0 || nh == 0)) begin
                m_ko  = 1;
                m_win = (nh == 0 ? 2 : 0) + (nn == 0 ? 1 : 0);
            end
            m_npc = nn; m_hp = nh;
            m_hit_npc = hn; m_hit_hp = hh;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.is_HPBeat = 0; bus.is_NPCBeat = 0;
        bus.HP_X = 10'd0; bus.NPC_X = 10'd0;
        bus.HP_X_Pos = 10'd100; bus.NPC_X_Pos = 10'd900;
        bus.DrawX = 10'd0; bus.DrawY = 10'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; tick(); rst = 0;
    endtask

    // n separate HP projectiles, each landing then waiting out the invulnerability window
    task automatic hit_npc_n(int n);
        bus.HP_X = 10'd300; bus.NPC_X_Pos = 10'd320;
        for (int i = 0; i < n; i++) begin
            bus.is_HPBeat = 1; tick();
            bus.is_HPBeat = 0;
            for (int j = 0; j < 30; j++) tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== {7'd100, 7'd100, 7'b0}) begin
            errors++; $display("FAIL reset_state got %h want %h", dut_vec(), {7'd100, 7'd100, 7'b0});
        end
    endtask

    task automatic test_first_hit();
        do_reset();
        bus.is_HPBeat = 1; bus.HP_X = 10'd300; bus.NPC_X_Pos = 10'd320;
        tick();
        checks++;
        if (bus.npc_health !== 7'd90 || bus.hit_npc !== 1'b1 || bus.npc_hurt !== 1'b1) begin
            errors++; $display("FAIL first_hit health=%0d hit=%b hurt=%b want 90 1 1",
                               bus.npc_health, bus.hit_npc, bus.npc_hurt);
        end
        tick();
        checks++;
        if (bus.hit_npc !== 1'b0 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL hit_pulse_width got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_hold_overlap();
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL hold_frame%0d got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.npc_health !== 7'd90) begin
            errors++; $display("FAIL proj_used_hold health=%0d want 90", bus.npc_health);
        end
        bus.is_HPBeat = 0; tick();
        bus.is_HPBeat = 1; tick();
        checks++;
        if (bus.npc_health !== 7'd80 || bus.hit_npc !== 1'b1) begin
            errors++; $display("FAIL rearm_hit health=%0d hit=%b want 80 1", bus.npc_health, bus.hit_npc);
        end
    endtask

    task automatic test_distance();
        logic [9:0] px [5] = '{10'd360, 10'd280, 10'd359, 10'd0, 10'd1023};
        logic [9:0] tx [5] = '{10'd320, 10'd320, 10'd320, 10'd1023, 10'd0};
        logic [6:0] eh [5] = '{7'd100, 7'd100, 7'd90, 7'd100, 7'd100};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            bus.is_HPBeat = 1; bus.HP_X = px[i]; bus.NPC_X_Pos = tx[i];
            bus.is_NPCBeat = 1; bus.NPC_X = px[i]; bus.HP_X_Pos = tx[i];
            tick();
            checks++;
            if (bus.npc_health !== eh[i] || bus.hp_health !== eh[i] || dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL distance%0d npc=%0d hp=%0d want %0d", i,
                                   bus.npc_health, bus.hp_health, eh[i]);
            end
        end
    endtask

    task automatic test_double_ko();
        do_reset();
        bus.HP_X = 10'd300; bus.NPC_X_Pos = 10'd320;
        bus.NPC_X = 10'd500; bus.HP_X_Pos = 10'd480;
        for (int i = 0; i < 9; i++) begin
            bus.is_HPBeat = 1; bus.is_NPCBeat = 1; tick();
            bus.is_HPBeat = 0; bus.is_NPCBeat = 0;
            for (int j = 0; j < 30; j++) tick();
        end
        checks++;
        if (bus.hp_health !== 7'd10 || bus.npc_health !== 7'd10) begin
            errors++; $display("FAIL pre_ko hp=%0d npc=%0d want 10 10", bus.hp_health, bus.npc_health);
        end
        bus.is_HPBeat = 1; bus.is_NPCBeat = 1; tick();
        checks++;
        if (dut_vec() !== {7'd0, 7'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11}) begin
            errors++; $display("FAIL double_ko got %h want %h", dut_vec(),
                               {7'd0, 7'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11});
        end
        for (int i = 0; i < 40; i++) begin
            bus.is_HPBeat = i[0]; bus.is_NPCBeat = i[1];
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL ko_frozen%0d got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.hp_hurt !== 1'b0 || bus.npc_hurt !== 1'b0 || bus.game_over !== 1'b1) begin
            errors++; $display("FAIL ko_drain hurt=%b%b go=%b want 00 1",
                               bus.hp_hurt, bus.npc_hurt, bus.game_over);
        end
    endtask

    task automatic test_invuln();
        bit saw15;
        do_reset();
        bus.HP_X = 10'd300; bus.NPC_X_Pos = 10'd330;
        bus.is_HPBeat = 1; tick();
        bus.is_HPBeat = 0;
        for (int i = 0; i < 14; i++) tick();
        bus.is_HPBeat = 1;
        saw15 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if (bus.npc_health !== 7'd90 || bus.hit_npc !== 1'b0) begin
                    errors++; $display("FAIL invuln_block health=%0d hit=%b want 90 0",
                                       bus.npc_health, bus.hit_npc);
                end
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL invuln_frame%0d got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.npc_health !== 7'd80) begin
            errors++; $display("FAIL invuln_expire health=%0d want 80", bus.npc_health);
        end
    endtask

    task automatic test_ko_reset_bars();
        do_reset();
        hit_npc_n(9);
        bus.is_HPBeat = 1; tick();
        checks++;
        if (bus.game_over !== 1'b1 || bus.winner !== 2'b01 || bus.npc_hurt !== 1'b1) begin
            errors++; $display("FAIL single_ko go=%b win=%b hurt=%b want 1 01 1",
                               bus.game_over, bus.winner, bus.npc_hurt);
        end
        rst = 1; tick(); rst = 0;
        checks++;
        if (dut_vec() !== {7'd100, 7'd100, 7'b0}) begin
            errors++; $display("FAIL ko_reset got %h want %h", dut_vec(), {7'd100, 7'd100, 7'b0});
        end
        bus.is_HPBeat = 0; tick();
        hit_npc_n(5);
        bus.DrawY = 10'd55; bus.DrawX = 10'd90; #1;
        checks++;
        if ({bus.is_blood, bus.blood_color} !== 2'b11 || bus.npc_health !== 7'd50) begin
            errors++; $display("FAIL bar_red blood=%b color=%b hp=%0d want 1 1 50",
                               bus.is_blood, bus.blood_color, bus.npc_health);
        end
        bus.DrawX = 10'd91; #1;
        checks++;
        if ({bus.is_blood, bus.blood_color} !== 2'b10) begin
            errors++; $display("FAIL bar_grey blood=%b color=%b want 1 0", bus.is_blood, bus.blood_color);
        end
        bus.DrawX = 10'd499; #1;
        checks++;
        if ({bus.is_blood, bus.blood_color} !== 2'b00) begin
            errors++; $display("FAIL bar_outside blood=%b color=%b want 0 0", bus.is_blood, bus.blood_color);
        end
        bus.DrawX = 10'd500; bus.DrawY = 10'd65; #1;
        checks++;
        if ({bus.is_blood, bus.blood_color} !== 2'b11) begin
            errors++; $display("FAIL bar_hp_edge blood=%b color=%b want 1 1", bus.is_blood, bus.blood_color);
        end
        bus.DrawY = 10'd66; #1;
        checks++;
        if (bus.is_blood !== 1'b0) begin
            errors++; $display("FAIL bar_row_edge blood=%b want 0", bus.is_blood);
        end
    endtask

    task automatic test_random();
        int off;
        logic [1:0] eb;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) bus.is_HPBeat  = ~bus.is_HPBeat;
            if ($urandom_range(0, 7) == 0) bus.is_NPCBeat = ~bus.is_NPCBeat;
            if ($urandom_range(0, 15) == 0) begin
                bus.NPC_X_Pos = 10'($urandom_range(0, 1023));
                bus.HP_X_Pos  = 10'($urandom_range(0, 1023));
            end
            off = int'(bus.NPC_X_Pos) + $urandom_range(0, 100) - 50;
            bus.HP_X  = 10'((off < 0) ? 0 : (off > 1023 ? 1023 : off));
            off = int'(bus.HP_X_Pos) + $urandom_range(0, 100) - 50;
            bus.NPC_X = 10'((off < 0) ? 0 : (off > 1023 ? 1023 : off));
            tick();
            rst = 0;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_frame%0d got %h want %h", i, dut_vec(), exp_vec());
            end
            bus.DrawX = 10'($urandom_range(30, 610));
            bus.DrawY = 10'($urandom_range(45, 70));
            #1;
            eb = exp_bar(int'(bus.DrawX), int'(bus.DrawY), m_hp, m_npc);
            checks++;
            if ({bus.is_blood, bus.blood_color} !== eb) begin
                errors++; $display("FAIL random_bar x=%0d y=%0d got %b want %b",
                                   bus.DrawX, bus.DrawY, {bus.is_blood, bus.blood_color}, eb);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_first_hit();
        test_hold_overlap();
        test_distance();
        test_double_ko();
        test_invuln();
        test_ko_reset_bars();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
